// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared types, constants and width helper for the SPI master
package spi_master_pkg;

  // Controller phases of one SPI transfer
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SCLK_HIGH,
    ST_SCLK_LOW,
    ST_DONE
  } state_e;

  // Half-period counter width: must hold freq+2 (the stretched START phase)
  localparam int DIV_W = 5;

  // Width of a field that encodes n distinct values, never narrower than one bit
  function automatic int spi_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_clk_div.sv
// rtl/spi_master_clk_div.sv - loadable down-counter that pulses on the last cycle of a phase
module spi_master_clk_div
  import spi_master_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Reload has priority so a phase can restart in the same cycle it expires
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Counter register; zero means idle and never ticks
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load of L gives exactly L cycles before the tick-cycle edge ends the phase
  assign tick_o = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master with valid/ready request and response ports
module spi_master
  import spi_master_pkg::*;
#(
  parameter int NBITS = 34,
  parameter int NCS   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  input  logic [NBITS-1:0]               recv_msg,
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic [NBITS-1:0]               send_msg,
  input  logic [spi_width(NBITS+1)-1:0]  packet_size,
  input  logic [spi_width(NCS)-1:0]      cs_addr,
  input  logic [3:0]                     freq,
  output logic [NCS-1:0]                 cs,
  output logic                           sclk,
  output logic                           mosi,
  input  logic                           miso
);

  localparam int PSW = spi_width(NBITS+1);
  localparam int CSW = spi_width(NCS);
  localparam logic [PSW-1:0] NB_P = PSW'(NBITS);

  state_e           state_q, state_d;
  logic [PSW-1:0]   n_q, n_d;
  logic [PSW-1:0]   bits_q, bits_d;
  logic [DIV_W-1:0] h_q, h_d;
  logic [NCS-1:0]   cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [NBITS-1:0] tx_q, tx_d;
  logic [NBITS-1:0] rx_q, rx_d;
  logic [NBITS-1:0] send_msg_q, send_msg_d;

  logic             div_load;
  logic [DIV_W-1:0] div_val;
  logic             div_tick;

  logic [PSW-1:0]   n_eff;
  logic [PSW-1:0]   shamt;
  logic [DIV_W-1:0] h_eff;
  logic [NBITS-1:0] aligned;
  logic [NCS-1:0]   cs_sel;

  // Request decode: effective length, MSB-aligned payload and half-period
  always_comb begin
    n_eff = packet_size;
    if (packet_size == '0 || packet_size > NB_P) begin
      n_eff = NB_P;
    end
    shamt   = NB_P - n_eff;
    aligned = recv_msg << shamt;
    h_eff   = DIV_W'(freq) + DIV_W'(1);
  end

  // One-cold chip-select decode; an out-of-range address selects nobody
  always_comb begin
    cs_sel = '1;
    for (int i = 0; i < NCS; i++) begin
      if (cs_addr == CSW'(i)) begin
        cs_sel[i] = 1'b0;
      end
    end
  end

  // Next-state and datapath updates; the divider is reloaded at every phase change
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    bits_d     = bits_q;
    h_d        = h_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    send_msg_d = send_msg_q;
    div_load   = 1'b0;
    div_val    = h_q;

    case (state_q)
      ST_IDLE: begin
        if (recv_val) begin
          state_d  = ST_START;
          n_d      = n_eff;
          h_d      = h_eff;
          cs_d     = cs_sel;
          sclk_d   = 1'b0;
          mosi_d   = aligned[NBITS-1];
          tx_d     = aligned << 1;
          rx_d     = '0;
          bits_d   = '0;
          div_load = 1'b1;
          // The extra setup cycle lands send_val at 1+H*(2N+1) after accept
          div_val  = h_eff + DIV_W'(1);
        end
      end

      ST_START: begin
        if (div_tick) begin
          state_d  = ST_SCLK_HIGH;
          sclk_d   = 1'b1;
          rx_d     = {rx_q[NBITS-2:0], miso};
          bits_d   = bits_q + PSW'(1);
          div_load = 1'b1;
        end
      end

      ST_SCLK_HIGH: begin
        if (div_tick) begin
          state_d  = ST_SCLK_LOW;
          sclk_d   = 1'b0;
          mosi_d   = tx_q[NBITS-1];
          tx_d     = tx_q << 1;
          div_load = 1'b1;
        end
      end

      ST_SCLK_LOW: begin
        if (div_tick) begin
          if (bits_q == n_q) begin
            state_d    = ST_DONE;
            cs_d       = '1;
            mosi_d     = 1'b0;
            send_msg_d = rx_q;
          end else begin
            state_d  = ST_SCLK_HIGH;
            sclk_d   = 1'b1;
            rx_d     = {rx_q[NBITS-2:0], miso};
            bits_d   = bits_q + PSW'(1);
            div_load = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (send_rdy) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = '1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset forces the bus idle immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      bits_q     <= '0;
      h_q        <= '0;
      cs_q       <= '1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      send_msg_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      bits_q     <= bits_d;
      h_q        <= h_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      send_msg_q <= send_msg_d;
    end
  end

  spi_master_clk_div u_clk_div (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (div_load),
    .load_val_i (div_val),
    .tick_o     (div_tick)
  );

  assign recv_rdy = (state_q == ST_IDLE);
  assign send_val = (state_q == ST_DONE);
  assign send_msg = send_msg_q;
  assign cs       = cs_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

  logic        clk;
  logic        reset;
  logic        recv_val, recv_rdy, send_val, send_rdy;
  logic [33:0] recv_msg, send_msg;
  logic [5:0]  packet_size;
  logic [1:0]  cs_addr;
  logic [3:0]  freq;
  logic [3:0]  cs;
  logic        sclk, mosi, miso;

  logic        b_recv_val, b_recv_rdy, b_send_val, b_send_rdy;
  logic [7:0]  b_recv_msg, b_send_msg;
  logic [3:0]  b_packet_size;
  logic [1:0]  b_cs_addr;
  logic [3:0]  b_freq;
  logic [2:0]  b_cs;
  logic        b_sclk, b_mosi, b_miso;

  int tests = 0;
  int failed = 0;

  int          lat, rises, hi_len, lo_len, mode_err, unstable, vsum;
  logic [63:0] mseq;
  logic [3:0]  cs_seen;
  logic [33:0] got_msg;
  logic        rdy_after, val_after;
  int          b_lat, b_rises, b_csbad;
  logic        bp;

  logic        use_minion, miso_const;
  logic [33:0] m_prev = '0;
  logic [33:0] m_rx = '0;
  logic [33:0] m_tx = '0;
  logic        m_miso = 1'b0;

  spi_master #(.NBITS(34), .NCS(4)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
    .packet_size(packet_size), .cs_addr(cs_addr), .freq(freq),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_master #(.NBITS(8), .NCS(3)) dut_b (
    .clk(clk), .reset(reset),
    .recv_val(b_recv_val), .recv_rdy(b_recv_rdy), .recv_msg(b_recv_msg),
    .send_val(b_send_val), .send_rdy(b_send_rdy), .send_msg(b_send_msg),
    .packet_size(b_packet_size), .cs_addr(b_cs_addr), .freq(b_freq),
    .cs(b_cs), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign miso = use_minion ? m_miso : miso_const;

  // Echo minion on cs[0]: replies with the previous packet it received
  always @(negedge cs[0]) if (use_minion) begin
    m_tx = m_prev; m_miso = m_prev[33]; m_rx = '0;
  end
  always @(posedge sclk) if (use_minion && !cs[0]) m_rx = {m_rx[32:0], mosi};
  always @(negedge sclk) if (use_minion && !cs[0]) begin
    m_tx = m_tx << 1; m_miso = m_tx[33];
  end
  always @(posedge cs[0]) if (use_minion) m_prev = m_rx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one request, scramble the sampled inputs, watch the bus until DONE, hold, then handshake
  task automatic run_xfer(input logic [33:0] msg, input logic [5:0] size, input logic [1:0] addr,
                          input logic [3:0] fr, input int hold);
    logic psclk, pmosi;
    int run;
    logic [33:0] held;
    recv_msg = msg; packet_size = size; cs_addr = addr; freq = fr; recv_val = 1'b1;
    @(posedge clk); #1;
    recv_val = 1'b0; packet_size = 6'd1; cs_addr = ~addr; freq = ~fr;
    lat = 0; rises = 0; hi_len = 0; lo_len = 0; mode_err = 0; unstable = 0;
    mseq = '0; cs_seen = '1; psclk = 1'b0; pmosi = mosi; run = 0;
    while (send_val !== 1'b1 && lat < 2000) begin
      @(posedge clk); #1; lat++;
      if (sclk != psclk) begin
        if (psclk && hi_len == 0) hi_len = run;
        if (!psclk && rises > 0 && lo_len == 0) lo_len = run;
        run = 1;
      end else begin
        run++;
      end
      if (sclk && !psclk) begin
        rises++; mseq = {mseq[62:0], mosi}; cs_seen = cs;
      end
      if (sclk && psclk && mosi !== pmosi) mode_err++;
      psclk = sclk; pmosi = mosi;
    end
    got_msg = send_msg;
    held = send_msg;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (send_val !== 1'b1 || send_msg !== held || recv_rdy !== 1'b0 || cs !== 4'hF) unstable++;
    end
    send_rdy = 1'b1;
    @(posedge clk); #1;
    send_rdy = 1'b0;
    rdy_after = recv_rdy; val_after = send_val;
  endtask

  initial begin
    reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0; recv_msg = '0;
    packet_size = '0; cs_addr = '0; freq = '0;
    b_recv_val = 1'b0; b_send_rdy = 1'b0; b_recv_msg = '0;
    b_packet_size = '0; b_cs_addr = '0; b_freq = '0; b_miso = 1'b1;
    use_minion = 1'b0; miso_const = 1'b1;

    // Reset state
    #22;
    check("rst_cs", cs, 4'hF);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_send_val", send_val, 1'b0);
    check("rst_send_msg", send_msg, 34'h0);
    check("rst_recv_rdy", recv_rdy, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;

    // 8-bit 0xA5, H=1, miso high
    miso_const = 1'b1;
    run_xfer(34'hA5, 6'd8, 2'd0, 4'd0, 0);
    check("a5_send_val", val_after === 1'b0 && got_msg !== 34'hx, 1'b1);
    check("a5_latency", lat, 18);
    check("a5_mosi_seq", mseq, 64'hA5);
    check("a5_rises", rises, 8);
    check("a5_send_msg", got_msg, 34'hFF);
    check("a5_cs", cs_seen, 4'b1110);
    check("a5_mode0", mode_err, 0);
    check("a5_rdy_after", rdy_after, 1'b1);

    // 4-bit 0xC, H=4, cs_addr 2, held 10 cycles in DONE
    miso_const = 1'b0;
    run_xfer(34'hC, 6'd4, 2'd2, 4'd3, 10);
    check("c_latency", lat, 37);
    check("c_mosi_seq", mseq, 64'hC);
    check("c_rises", rises, 4);
    check("c_hi_len", hi_len, 4);
    check("c_lo_len", lo_len, 4);
    check("c_cs", cs_seen, 4'b1011);
    check("c_send_msg", got_msg, 34'h0);
    check("c_hold_stable", unstable, 0);
    check("c_rdy_after", rdy_after, 1'b1);
    check("c_val_after", val_after, 1'b0);

    // Echo minion, full 34-bit packets, H=2
    use_minion = 1'b1;
    run_xfer(34'h1_2345_6789, 6'd0, 2'd0, 4'd1, 0);
    check("echo1_send_msg", got_msg, 34'h0);
    check("echo1_latency", lat, 139);
    check("echo1_mosi_seq", mseq, 64'h1_2345_6789);
    run_xfer(34'h0, 6'd0, 2'd0, 4'd1, 0);
    check("echo2_send_msg", got_msg, 34'h1_2345_6789);
    use_minion = 1'b0;

    // Reset in the middle of a transfer
    miso_const = 1'b1;
    recv_msg = 34'hF0; packet_size = 6'd8; cs_addr = 2'd1; freq = 4'd1; recv_val = 1'b1;
    @(posedge clk); #1;
    recv_val = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
    end
    check("mid_sclk_before", sclk, 1'b1);
    check("mid_cs_before", cs, 4'b1101);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_cs", cs, 4'hF);
    check("mid_rst_sclk", sclk, 1'b0);
    check("mid_rst_send_val", send_val, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    vsum = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (send_val !== 1'b0) vsum++;
    end
    check("mid_no_send_val", vsum, 0);
    check("mid_recv_rdy", recv_rdy, 1'b1);
    miso_const = 1'b0;
    run_xfer(34'h3C, 6'd8, 2'd1, 4'd0, 0);
    check("post_rst_latency", lat, 18);
    check("post_rst_mosi_seq", mseq, 64'h3C);
    check("post_rst_send_msg", got_msg, 34'h0);
    check("post_rst_cs", cs_seen, 4'b1101);

    // Out-of-range chip select on the 8-bit, 3-select instance
    b_recv_msg = 8'h5A; b_packet_size = 4'd0; b_cs_addr = 2'd3; b_freq = 4'd0; b_recv_val = 1'b1;
    @(posedge clk); #1;
    b_recv_val = 1'b0;
    b_lat = 0; b_rises = 0; b_csbad = 0; bp = 1'b0;
    while (b_send_val !== 1'b1 && b_lat < 500) begin
      @(posedge clk); #1; b_lat++;
      if (b_cs !== 3'b111) b_csbad++;
      if (b_sclk && !bp) b_rises++;
      bp = b_sclk;
    end
    check("oor_latency", b_lat, 18);
    check("oor_cs_high", b_csbad, 0);
    check("oor_rises", b_rises, 8);
    check("oor_send_msg", b_send_msg, 8'hFF);
    b_send_rdy = 1'b1;
    @(posedge clk); #1;
    b_send_rdy = 1'b0;
    check("oor_rdy_after", b_recv_rdy, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
